pe_dbuf_sat: RTL and testbench

//  Parametrised weight-stationary systolic-array processing element (next-gen PE).

---
 rtl/pe_dbuf_sat.sv | 178 +++++++++++++++++
 tb/tb_pe_dbuf_sat.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_dbuf_sat.sv
// Weight-stationary systolic PE with a double-buffered weight, rounded fixed-point MAC,
// saturating (or wrapping) partial sum and a sticky overflow flag.
module pe_dbuf_sat #(
  parameter int DW   = 16,
  parameter int FRAC = 8,
  parameter int AW   = 24,
  parameter int SAT  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] hrzt_in,
  input  logic          hrzt_vld_in,
  input  logic [AW-1:0] vrtc_in,
  input  logic          vrtc_vld_in,
  input  logic          wload_in,
  input  logic          wswap_in,
  input  logic          clr_ovf,
  output logic [DW-1:0] hrzt_out,
  output logic          hrzt_vld_out,
  output logic [AW-1:0] vrtc_out,
  output logic          vrtc_vld_out,
  output logic          wload_out,
  output logic          wswap_out,
  output logic          ovf
);

  // One guard bit above the product so adding the rounding constant can never overflow.
  localparam int PW = 2 * DW + 1;
  localparam int SW = ((PW > AW) ? PW : AW) + 1;
  localparam logic signed [PW-1:0] RND =
    (FRAC > 0) ? (PW'(1'b1) << ((FRAC > 0) ? (FRAC - 1) : 0)) : '0;
  localparam logic signed [SW-1:0] MAX_S = (SW'(1'b1) << (AW - 1)) - SW'(1'b1);
  localparam logic signed [SW-1:0] MIN_S = -(SW'(1'b1) << (AW - 1));

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_LOAD = 2'd1,
    MODE_MAC  = 2'd2
  } mode_e;

  // Returns {out_of_range, result}; result is clamped or wrapped depending on SAT.
  function automatic logic [AW:0] clamp_fn(input logic signed [SW-1:0] sum);
    logic [AW:0] res;
    if (sum > MAX_S) begin
      res = {1'b1, (SAT != 0) ? MAX_S[AW-1:0] : sum[AW-1:0]};
    end else if (sum < MIN_S) begin
      res = {1'b1, (SAT != 0) ? MIN_S[AW-1:0] : sum[AW-1:0]};
    end else begin
      res = {1'b0, sum[AW-1:0]};
    end
    return res;
  endfunction

  logic [DW-1:0]        hrzt_r;
  logic                 hrzt_vld_r;
  logic [AW-1:0]        vrtc_r;
  logic                 vrtc_vld_r;
  logic                 wload_r;
  logic                 wswap_r;
  logic                 ovf_r;
  logic signed [DW-1:0] shadow_r;
  logic signed [DW-1:0] active_r;

  mode_e                  mode_s;
  logic signed [2*DW-1:0] prod_s;
  logic signed [PW-1:0]   prod_rnd_s;
  logic signed [SW-1:0]   sum_s;
  logic [AW-1:0]          mac_val_s;
  logic                   mac_ovf_s;
  logic [AW-1:0]          vrtc_nxt_s;
  logic                   vrtc_vld_nxt_s;
  logic [DW-1:0]          shadow_nxt_s;
  logic [DW-1:0]          active_nxt_s;
  logic                   ovf_hit_s;
  logic                   ovf_nxt_s;

  // Mode decode: a weight load owns the vertical path over any MAC.
  always_comb begin
    mode_s = MODE_IDLE;
    if (wload_in) begin
      mode_s = MODE_LOAD;
    end else if (hrzt_vld_in && vrtc_vld_in) begin
      mode_s = MODE_MAC;
    end else begin
      mode_s = MODE_IDLE;
    end
  end

  // Full-precision product, round half up, then accumulate without intermediate loss.
  always_comb begin
    prod_s                 = active_r * $signed(hrzt_in);
    prod_rnd_s             = (PW'(prod_s) + RND) >>> FRAC;
    sum_s                  = SW'(prod_rnd_s) + SW'($signed(vrtc_in));
    {mac_ovf_s, mac_val_s} = clamp_fn(sum_s);
  end

  // Next-state for the vertical path, weight buffers and sticky flag.
  always_comb begin
    vrtc_nxt_s     = vrtc_r;
    vrtc_vld_nxt_s = 1'b0;
    shadow_nxt_s   = shadow_r;
    ovf_hit_s      = 1'b0;
    case (mode_s)
      MODE_LOAD: begin
        if (vrtc_vld_in) begin
          shadow_nxt_s   = vrtc_in[DW-1:0];
          vrtc_nxt_s     = AW'(shadow_r);
          vrtc_vld_nxt_s = 1'b1;
        end else begin
          vrtc_nxt_s     = vrtc_r;
          vrtc_vld_nxt_s = 1'b0;
        end
      end
      MODE_MAC: begin
        vrtc_nxt_s     = mac_val_s;
        vrtc_vld_nxt_s = 1'b1;
        ovf_hit_s      = mac_ovf_s;
      end
      MODE_IDLE: begin
        vrtc_nxt_s     = vrtc_r;
        vrtc_vld_nxt_s = 1'b0;
      end
      default: begin
        vrtc_nxt_s     = vrtc_r;
        vrtc_vld_nxt_s = 1'b0;
      end
    endcase

    // Swap reads the shadow as it was before this edge, so a same-cycle load is not promoted.
    if (wswap_in) begin
      active_nxt_s = shadow_r;
    end else begin
      active_nxt_s = active_r;
    end

    if (ovf_hit_s) begin
      ovf_nxt_s = 1'b1;
    end else if (clr_ovf) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end
  end

  // State and output registers; reset discards all in-flight data and both weights.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hrzt_r     <= '0;
      hrzt_vld_r <= 1'b0;
      vrtc_r     <= '0;
      vrtc_vld_r <= 1'b0;
      wload_r    <= 1'b0;
      wswap_r    <= 1'b0;
      ovf_r      <= 1'b0;
      shadow_r   <= '0;
      active_r   <= '0;
    end else begin
      hrzt_r     <= hrzt_in;
      hrzt_vld_r <= hrzt_vld_in;
      vrtc_r     <= vrtc_nxt_s;
      vrtc_vld_r <= vrtc_vld_nxt_s;
      wload_r    <= wload_in;
      wswap_r    <= wswap_in;
      ovf_r      <= ovf_nxt_s;
      shadow_r   <= shadow_nxt_s;
      active_r   <= active_nxt_s;
    end
  end

  assign hrzt_out     = hrzt_r;
  assign hrzt_vld_out = hrzt_vld_r;
  assign vrtc_out     = vrtc_r;
  assign vrtc_vld_out = vrtc_vld_r;
  assign wload_out    = wload_r;
  assign wswap_out    = wswap_r;
  assign ovf          = ovf_r;

endmodule

// File: tb/tb_pe_dbuf_sat.sv
// Bench for pe_dbuf_sat: directed and random single-PE checks (SAT=1 and SAT=0 builds)
// against an arithmetic reference, plus a 4x4 array with mid-stream reset and matmul check.
module tb_pe_dbuf_sat;

  localparam int T = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] hin;
  logic        hv, vv, wl, ws, clr;
  logic [23:0] vin;

  logic [15:0] ho_s, ho_w;
  logic [23:0] vo_s, vo_w;
  logic        hvo_s, vvo_s, wlo_s, wso_s, ov_s;
  logic        hvo_w, vvo_w, wlo_w, wso_w, ov_w;

  int total = 0;
  int bad   = 0;

  pe_dbuf_sat #(.DW(16), .FRAC(8), .AW(24), .SAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .hrzt_in(hin), .hrzt_vld_in(hv), .vrtc_in(vin),
    .vrtc_vld_in(vv), .wload_in(wl), .wswap_in(ws), .clr_ovf(clr),
    .hrzt_out(ho_s), .hrzt_vld_out(hvo_s), .vrtc_out(vo_s), .vrtc_vld_out(vvo_s),
    .wload_out(wlo_s), .wswap_out(wso_s), .ovf(ov_s));

  pe_dbuf_sat #(.DW(16), .FRAC(8), .AW(24), .SAT(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .hrzt_in(hin), .hrzt_vld_in(hv), .vrtc_in(vin),
    .vrtc_vld_in(vv), .wload_in(wl), .wswap_in(ws), .clr_ovf(clr),
    .hrzt_out(ho_w), .hrzt_vld_out(hvo_w), .vrtc_out(vo_w), .vrtc_vld_out(vvo_w),
    .wload_out(wlo_w), .wswap_out(wso_w), .ovf(ov_w));

  // 4x4 array: activations move right, partial sums / weights / control move down
  logic [15:0] l_h [4];
  logic        l_hv [4];
  logic [23:0] t_v [4];
  logic        t_vv [4], t_wl [4], t_ws [4];
  logic        a_clr;
  logic [15:0] h_i [4][4], h_o [4][4];
  logic        hv_i [4][4], hv_o [4][4];
  logic [23:0] v_i [4][4], v_o [4][4];
  logic        vv_i [4][4], vv_o [4][4], wl_i [4][4], wl_o [4][4];
  logic        ws_i [4][4], ws_o [4][4], ov_o [4][4];

  for (genvar r = 0; r < 4; r++) begin : g_r
    for (genvar c = 0; c < 4; c++) begin : g_c
      if (c == 0) begin : g_left
        assign h_i[r][c]  = l_h[r];
        assign hv_i[r][c] = l_hv[r];
      end else begin : g_hop
        assign h_i[r][c]  = h_o[r][c-1];
        assign hv_i[r][c] = hv_o[r][c-1];
      end
      if (r == 0) begin : g_top
        assign v_i[r][c]  = t_v[c];
        assign vv_i[r][c] = t_vv[c];
        assign wl_i[r][c] = t_wl[c];
        assign ws_i[r][c] = t_ws[c];
      end else begin : g_vop
        assign v_i[r][c]  = v_o[r-1][c];
        assign vv_i[r][c] = vv_o[r-1][c];
        assign wl_i[r][c] = wl_o[r-1][c];
        assign ws_i[r][c] = ws_o[r-1][c];
      end
      pe_dbuf_sat #(.DW(16), .FRAC(8), .AW(24), .SAT(1)) u_pe (
        .clk(clk), .rst_n(rst_n), .hrzt_in(h_i[r][c]), .hrzt_vld_in(hv_i[r][c]),
        .vrtc_in(v_i[r][c]), .vrtc_vld_in(vv_i[r][c]), .wload_in(wl_i[r][c]),
        .wswap_in(ws_i[r][c]), .clr_ovf(a_clr),
        .hrzt_out(h_o[r][c]), .hrzt_vld_out(hv_o[r][c]), .vrtc_out(v_o[r][c]),
        .vrtc_vld_out(vv_o[r][c]), .wload_out(wl_o[r][c]), .wswap_out(ws_o[r][c]),
        .ovf(ov_o[r][c]));
    end
  end

  // reference model state for the single PEs
  logic [15:0] m_sh, m_act, m_h;
  logic        m_hv, m_wl, m_ws, m_vv, m_ov_s, m_ov_w;
  logic [23:0] m_vo_s, m_vo_w;

  int W [4][4];
  int X [T][4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sx16(input logic [15:0] v);
    return longint'(signed'(v));
  endfunction

  function automatic longint sx24(input logic [23:0] v);
    return longint'(signed'(v));
  endfunction

  function automatic longint rnd_q8(input longint p);
    return (p + 64'sd128) >>> 8;
  endfunction

  task automatic mdl_reset();
    m_sh = 16'h0; m_act = 16'h0; m_h = 16'h0;
    m_hv = 1'b0; m_wl = 1'b0; m_ws = 1'b0; m_vv = 1'b0;
    m_ov_s = 1'b0; m_ov_w = 1'b0; m_vo_s = 24'h0; m_vo_w = 24'h0;
  endtask

  // one clock of the behavioural rules, evaluated with the inputs present at the edge
  task automatic mdl();
    longint      s;
    logic [15:0] old_sh;
    logic        hit;
    old_sh = m_sh;
    hit    = 1'b0;
    m_h = hin; m_hv = hv; m_wl = wl; m_ws = ws;
    if (wl) begin
      if (vv) begin
        m_sh   = vin[15:0];
        m_vo_s = 24'(sx16(old_sh));
        m_vo_w = m_vo_s;
        m_vv   = 1'b1;
      end else begin
        m_vv = 1'b0;
      end
    end else if (hv && vv) begin
      s = rnd_q8(sx16(m_act) * sx16(hin)) + sx24(vin);
      if (s > 64'sd8388607) begin
        m_vo_s = 24'h7FFFFF; hit = 1'b1;
      end else if (s < -64'sd8388608) begin
        m_vo_s = 24'h800000; hit = 1'b1;
      end else begin
        m_vo_s = 24'(s);
      end
      m_vo_w = 24'(s);
      m_vv   = 1'b1;
    end else begin
      m_vv = 1'b0;
    end
    if (ws) m_act = old_sh;
    if (hit) begin
      m_ov_s = 1'b1; m_ov_w = 1'b1;
    end else if (clr) begin
      m_ov_s = 1'b0; m_ov_w = 1'b0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    mdl();
    #1;
    chk("hrzt_out", ho_s, m_h);
    chk("hrzt_vld_out", hvo_s, m_hv);
    chk("wload_out", wlo_s, m_wl);
    chk("wswap_out", wso_s, m_ws);
    chk("vrtc_vld_out", vvo_s, m_vv);
    chk("vrtc_out_sat", vo_s, m_vo_s);
    chk("ovf_sat", ov_s, m_ov_s);
    chk("wrap_side", {ho_w, hvo_w, wlo_w, wso_w, vvo_w}, {m_h, m_hv, m_wl, m_ws, m_vv});
    chk("vrtc_out_wrap", vo_w, m_vo_w);
    chk("ovf_wrap", ov_w, m_ov_w);
  endtask

  task automatic idle();
    hv = 1'b0; vv = 1'b0; wl = 1'b0; ws = 1'b0; clr = 1'b0;
    hin = 16'h0; vin = 24'h0;
  endtask

  task automatic load_w(input logic [15:0] w);
    idle(); wl = 1'b1; vv = 1'b1; vin = {8'h00, w};
    cyc();
    idle(); ws = 1'b1;
    cyc();
    idle();
  endtask

  task automatic mac(input logic [15:0] h, input logic [23:0] v);
    hv = 1'b1; vv = 1'b1; wl = 1'b0; hin = h; vin = v;
    cyc();
    idle();
  endtask

  function automatic logic [23:0] gold(input int t, input int c);
    longint acc = 64'sd0;
    for (int r = 0; r < 4; r++) acc += rnd_q8(longint'(X[t][r]) * longint'(W[r][c]));
    return 24'(acc);
  endfunction

  task automatic arr_idle();
    for (int i = 0; i < 4; i++) begin
      l_h[i] = 16'h0; l_hv[i] = 1'b0; t_v[i] = 24'h0;
      t_vv[i] = 1'b0; t_wl[i] = 1'b0; t_ws[i] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // bottom row's weights go in first so they finish in the bottom row
  task automatic arr_load();
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        t_wl[c] = 1'b1; t_vv[c] = 1'b1; t_v[c] = {8'h00, 16'(W[3-k][c])};
      end
      tick();
    end
    arr_idle();
    for (int k = 0; k < 4; k++) tick();
    for (int c = 0; c < 4; c++) t_ws[c] = 1'b1;
    tick();
    arr_idle();
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic arr_mac(input int ncyc, input bit exp_zero);
    int cnt [4];
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    for (int n = 0; n < ncyc; n++) begin
      for (int r = 0; r < 4; r++) begin
        if (n - r >= 0 && n - r < T) begin
          l_h[r] = 16'(X[n-r][r]); l_hv[r] = 1'b1;
        end else begin
          l_h[r] = 16'h0; l_hv[r] = 1'b0;
        end
      end
      for (int c = 0; c < 4; c++) begin
        t_v[c]  = 24'h0;
        t_vv[c] = (n - c >= 0 && n - c < T);
      end
      tick();
      for (int c = 0; c < 4; c++) begin
        if (vv_o[3][c]) begin
          if (cnt[c] < T) chk("arr_result", v_o[3][c], exp_zero ? 24'h0 : gold(cnt[c], c));
          cnt[c]++;
        end
      end
    end
    if (ncyc >= T + 8) begin
      for (int c = 0; c < 4; c++) chk("arr_count", cnt[c], T);
    end
  endtask

  task automatic rand_xw();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) W[r][c] = int'($urandom_range(0, 1023)) - 512;
    end
    for (int t = 0; t < T; t++) begin
      for (int r = 0; r < 4; r++) X[t][r] = int'($urandom_range(0, 1023)) - 512;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_clr = 1'b0;
    idle();
    arr_idle();
    mdl_reset();
    #17;
    chk("reset_sat", {ho_s, hvo_s, vo_s, vvo_s, wlo_s, wso_s, ov_s}, 64'h0);
    chk("reset_wrap", {ho_w, hvo_w, vo_w, vvo_w, wlo_w, wso_w, ov_w}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // load chain and swap timing
    wl = 1'b1; vv = 1'b1; vin = 24'h000011; cyc(); chk("t1_shift0", vo_s, 24'h000000);
    vin = 24'h000022; cyc(); chk("t1_shift1", vo_s, 24'h000011);
    vin = 24'h000033; cyc(); chk("t1_shift2", vo_s, 24'h000022);
    chk("t1_vld", vvo_s, 1'b1);
    idle(); ws = 1'b1; hv = 1'b1; vv = 1'b1; hin = 16'h0100; vin = 24'h000005;
    cyc(); chk("t1_swap_old_w", vo_s, 24'h000005);
    ws = 1'b0; cyc(); chk("t1_new_w", vo_s, 24'h000038);
    idle();

    // basic MAC
    load_w(16'h0200); mac(16'h0180, 24'h000100);
    chk("t2_mac", vo_s, 24'h000400); chk("t2_vld", vvo_s, 1'b1); chk("t2_ovf", ov_s, 1'b0);

    // rounding half up
    load_w(16'h0001); mac(16'h0080, 24'h000010); chk("t3_rnd_pos", vo_s, 24'h000011);
    load_w(16'hFFFF); mac(16'h0080, 24'h000010); chk("t3_rnd_half", vo_s, 24'h000010);
    mac(16'h0081, 24'h000010); chk("t3_rnd_neg", vo_s, 24'h00000F);

    // saturation / wrap and sticky flag
    load_w(16'h7FFF); mac(16'h7FFF, 24'h7FFF00);
    chk("t4_sat_pos", vo_s, 24'h7FFFFF); chk("t4_wrap_pos", vo_w, 24'hBFFE00);
    chk("t4_ovf_pos", {ov_s, ov_w}, 2'b11);
    clr = 1'b1; cyc(); idle(); chk("t4_clr", {ov_s, ov_w}, 2'b00);
    load_w(16'h8000); mac(16'h7FFF, 24'h800000);
    chk("t4_sat_neg", vo_s, 24'h800000); chk("t4_wrap_neg", vo_w, 24'h400080);
    chk("t4_ovf_neg", ov_s, 1'b1);
    clr = 1'b1; mac(16'h7FFF, 24'h800000); chk("t4_set_beats_clr", ov_s, 1'b1);
    clr = 1'b1; cyc(); idle(); chk("t4_clr2", ov_s, 1'b0);

    // lone valids are dropped
    hv = 1'b1; hin = 16'hABCD; cyc(); idle();
    chk("t5_vld_drop", vvo_s, 1'b0); chk("t5_hold", vo_s, 24'h800000); chk("t5_fwd", ho_s, 16'hABCD);
    wl = 1'b1; vin = 24'h000077; cyc(); idle();
    chk("t5_load_novld", vvo_s, 1'b0); chk("t5_load_hold", vo_s, 24'h800000);

    // random traffic against the reference
    for (int i = 0; i < 400; i++) begin
      hin = 16'($urandom);
      vin = 24'($urandom);
      hv  = ($urandom_range(0, 3) != 0);
      vv  = ($urandom_range(0, 3) != 0);
      wl  = ($urandom_range(0, 3) == 0);
      ws  = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 7) == 0);
      cyc();
    end
    idle();

    // 4x4 array: load, start streaming, then reset asynchronously mid-stream
    rand_xw();
    arr_load();
    arr_mac(5, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        chk("arr_async_rst", {h_o[r][c], hv_o[r][c], v_o[r][c], vv_o[r][c],
                              wl_o[r][c], ws_o[r][c], ov_o[r][c]}, 64'h0);
      end
    end
    chk("pe_async_rst", {vo_s, vvo_s, ov_s, vo_w, ov_w}, 64'h0);
    arr_idle();
    @(negedge clk);
    rst_n = 1'b1;

    // weights were cleared: every product is zero
    arr_mac(T + 8, 1'b1);
    arr_idle();
    tick();

    // full reload and reference matmul
    rand_xw();
    arr_load();
    arr_mac(T + 8, 1'b0);
    arr_idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
